ram_arbiter_cg: RTL

Two-requester round-robin arbiter and sequencer for the single-port 256x8 block RAM (clock enable, write enable, registered read output). It accepts read/write requests from ports A and B, issues exactly one RAM access at a time, and waits out the RAM read latency. It returns registered read data and a completion pulse to the requester that owns the access. It sits between two datapath clients and one RAM_CG-style memory instance.

---
 rtl/ram_arbiter_cg.sv | 95 +++++++++
 1 files changed

// File: rtl/ram_arbiter_cg.sv
// ram_arbiter_cg: two-port round-robin arbiter and sequencer for a single-port block RAM
//   CLK, RST                  clock, synchronous active-high reset
//   req/we/addr/din_{a,b}     per-port request, sampled only at the grant edge
//   gnt_{a,b}                 combinational grant, IDLE only
//   done_{a,b}, rdata_{a,b}   registered completion pulse and held read data
//   ram_en/we/addr/din/rst    RAM control and write data, ram_dout RAM read data
//   busy                      high in every state except IDLE
module ram_arbiter_cg #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic              gnt_a,
    output logic              done_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic              gnt_b,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_rst,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t     state, state_nx;
    logic       last_b, owner_b, we_q, sel_b, take, fire;
    logic [1:0] cnt;
    // B wins when it is the sole requester, or on a tie when A was granted last
    assign sel_b   = req_b && (!req_a || !last_b);
    assign take    = (state == IDLE) && !RST && (req_a || req_b);
    assign gnt_a   = take && !sel_b;
    assign gnt_b   = take && sel_b;
    assign ram_en  = state == ISSUE;
    assign ram_we  = ram_en && we_q;
    assign ram_rst = RST;
    assign busy    = state != IDLE;
    // completion: writes finish at the issue edge, reads once the latency counter drains
    assign fire    = (state == ISSUE && we_q) || (state == WAIT && cnt == 2'd0);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? ISSUE : IDLE;
            ISSUE:   state_nx = we_q ? IDLE : WAIT;
            WAIT:    state_nx = (cnt == 2'd0) ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            owner_b  <= 1'b0;
            we_q     <= 1'b0;
            cnt      <= 2'd0;
            ram_addr <= '0;
            ram_din  <= '0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            state  <= state_nx;
            done_a <= fire && !owner_b;
            done_b <= fire && owner_b;
            if (take) begin
                owner_b  <= sel_b;
                last_b   <= sel_b;
                we_q     <= sel_b ? we_b : we_a;
                ram_addr <= sel_b ? addr_b : addr_a;
                ram_din  <= sel_b ? din_b : din_a;
            end
            if (state == ISSUE && !we_q)
                cnt <= 2'(RD_LAT - 1);
            if (state == WAIT && cnt != 2'd0)
                cnt <= cnt - 2'd1;
            if (state == WAIT && cnt == 2'd0 && owner_b)
                rdata_b <= ram_dout;
            if (state == WAIT && cnt == 2'd0 && !owner_b)
                rdata_a <= ram_dout;
        end
    end
endmodule
